shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  frame start; begins a new N-bit word.
REQ-005 SHALL have port sin_valid  input  1  qualifies sin this cycle.
REQ-006 SHALL have port sin  input  1  serial data bit.
REQ-007 SHALL have port dir  input  1  bit order: 1 = first bit lands in MSB (left shift), 0 = first bit lands in LSB (right shift).
REQ-008 SHALL have port dout  output  N  assembled word.
REQ-009 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 SHALL implement states IDLE and SHIFT; busy = (state == SHIFT).
REQ-014 SHALL, in IDLE with start=1: enter SHIFT, clear the bit counter, and latch dir for the whole frame.
REQ-015 SHALL, when start and sin_valid are both 1, capture sin as bit 0 of the new frame on that edge.
REQ-016 SHALL, in SHIFT, shift sin into the capture register on each edge with sin_valid=1: dir=1 as {cap[N-2:0], sin}, dir=0 as {sin, cap[N-1:1]}.
REQ-017 SHALL hold the capture register and counter unchanged on cycles with sin_valid=0; gaps of any length are legal.
REQ-018 SHALL ignore dir changes during SHIFT; only the dir value latched at start applies.
REQ-019 SHALL, on the edge sampling the Nth bit, complete the word and return to IDLE (or remain in SHIFT with a cleared counter if start=1 that cycle).
REQ-020 SHALL, at completion, load dout and set dout_valid=1 on that same edge if dout_valid=0, or if dout_valid=1 and dout_ready=1 that cycle; latency = 1 edge from the Nth bit to dout_valid visible.
REQ-021 SHALL, at completion with dout_valid=1 and dout_ready=0, discard the new word, keep dout unchanged, and set overrun=1.
REQ-022 SHALL clear dout_valid on an edge with dout_valid=1, dout_ready=1, and no word completing.
REQ-023 SHALL hold dout stable while dout_valid=1 and the word is not consumed.
REQ-024 SHALL, on start=1 during SHIFT, abandon the partial word (no output, no overrun), restart the counter, and relatch dir.
REQ-025 SHALL ignore sin_valid in IDLE when start=0.
REQ-026 SHALL clear overrun only by rst.

Reset
REQ-027 SHALL, on rst=1 at an edge, force state=IDLE, counter=0, capture register=0, dout=0, dout_valid=0, overrun=0, and busy=0.
REQ-028 SHALL give rst priority over start, sin_valid, and dout_ready; a partial frame is discarded.

Structure
REQ-029 SHALL take the state typedef (IDLE/SHIFT) and the default width constant from shared package shift_pkg.
REQ-030 SHALL size the counter as $clog2(N) bits and compare it against N-1.
REQ-031 SHALL place the capture register and bit counter in one sub-module, shift_capture, with control FSM and output register in the top.

Verification
REQ-032 SHALL verify: N=8, dir=1, start with bits 1,0,1,1,0,0,1,0 on consecutive cycles, dout_ready=1 -> dout=8'hB2, dout_valid=1 one edge after the 8th bit.
REQ-033 SHALL verify: same bits with dir=0 -> dout=8'h4D.
REQ-034 SHALL verify: same as REQ-032 with sin_valid low for 3 cycles between bits 3 and 4 -> dout=8'hB2, busy=1 throughout the gap.
REQ-035 SHALL verify: two full words with dout_ready=0 -> first word held in dout, overrun=1 after the second word's 8th bit, and rst clears it to 0.
REQ-036 SHALL verify: start reasserted after 5 bits, then 8 bits 0xFF with dir=1 -> dout=8'hFF, one dout_valid only, overrun=0.
REQ-037 SHALL verify: rst asserted after 4 bits -> all outputs 0 the next cycle, and a new full frame decodes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift deserializer.
//   DEFAULT_N : default word width in bits
//   state_e   : control FSM states (IDLE waits for a frame start, SHIFT
//               collects bits of a frame)
package shift_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_capture.sv
// Capture register and bit counter of the shift deserializer.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clear_i     : start of a new frame; counter restarts
//   shift_en_i  : shift sin_i into the capture register this edge
//   dir_i       : 1 = shift left (first bit ends in MSB), 0 = shift right
//   sin_i       : serial data bit
//   word_o      : capture register value after shifting in sin_i; this is
//                 the completed word on the edge that samples the last bit
//   last_o      : counter holds N-1, i.e. the next shifted bit completes a word
module shift_capture
  import shift_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         shift_en_i,
  input  logic         dir_i,
  input  logic         sin_i,
  output logic [N-1:0] word_o,
  output logic         last_o
);

  logic [N-1:0]     cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     shifted;

  assign shifted = dir_i ? {cap_q[N-2:0], sin_i} : {sin_i, cap_q[N-1:1]};
  assign word_o  = shifted;
  assign last_o  = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    cap_d = cap_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      // A bit arriving together with the frame start is bit 0 of the frame.
      cnt_d = shift_en_i ? CNT_W'(1) : '0;
      if (shift_en_i) cap_d = shifted;
    end else if (shift_en_i) begin
      cap_d = shifted;
      cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else begin
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter with start-delimited frames and a one-word
// output register.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : begins a new N-bit frame (abandons any partial frame)
//   sin_valid  : qualifies sin
//   sin        : serial data bit
//   dir        : bit order, latched at frame start (1 = MSB first)
//   dout       : assembled word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout
//   busy       : a frame is in progress (FSM is in SHIFT)
//   overrun    : sticky; a completed word was dropped because dout was full
//
// Output handshake: a word transfers on any edge where dout_valid=1 and
// dout_ready=1. dout is stable while dout_valid=1 and not consumed. A word
// completing while dout is full and not being consumed is dropped and raises
// overrun; a word completing on the same edge as a consumption replaces it.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sin_valid,
  input  logic         sin,
  input  logic         dir,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         overrun
);

  state_e       state_q, state_d;
  logic         dir_q, dir_d;
  logic [N-1:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic         overrun_q, overrun_d;

  logic         cap_clear, cap_shift, dir_eff, dir_load;
  logic         last;
  logic [N-1:0] word;
  logic         frame_done;

  // The Nth bit of a frame is being sampled this edge.
  assign frame_done = (state_q == SHIFT) && sin_valid && last;

  shift_capture #(.N(N)) u_capture (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cap_clear),
    .shift_en_i (cap_shift),
    .dir_i      (dir_eff),
    .sin_i      (sin),
    .word_o     (word),
    .last_o     (last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (frame_done && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == SHIFT);
    cap_clear = 1'b0;
    cap_shift = 1'b0;
    dir_eff   = dir_q;
    dir_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_clear = 1'b1;
          cap_shift = sin_valid;
          dir_eff   = dir;
          dir_load  = 1'b1;
        end
      end
      SHIFT: begin
        if (frame_done) begin
          // The finishing bit belongs to the current frame; a start on this
          // edge opens the next frame with an empty counter (which the
          // counter wrap already provides).
          cap_shift = 1'b1;
          dir_load  = start;
        end else if (start) begin
          cap_clear = 1'b1;
          cap_shift = sin_valid;
          dir_eff   = dir;
          dir_load  = 1'b1;
        end else begin
          cap_shift = sin_valid;
        end
      end
      default: ;
    endcase
  end

  assign dir_d = dir_load ? dir : dir_q;

  // Output register
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    if (frame_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, sin_valid, sin, dir, dout_ready;
  logic [N-1:0] dout;
  logic         dout_valid, busy, overrun;

  always #5 clk = ~clk;

  shift_deserializer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sin_valid  (sin_valid),
    .sin        (sin),
    .dir        (dir),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  // Reference model: frame contents kept as a list of received bits.
  logic         m_in_frame = 1'b0;
  logic         m_dir = 1'b0;
  logic         m_bits[$];
  logic [N-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  logic         m_over = 1'b0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bit i of the frame goes to position N-1-i (MSB first) or i (LSB first).
  function automatic logic [N-1:0] assemble(input logic fdir);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (fdir) w[N-1-i] = m_bits[i];
      else      w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic v, input logic b,
                            input logic d, input logic rd, input logic [N-1:0] pre_dout);
    logic         done;
    logic         consumed;
    logic [N-1:0] w;
    if (r) begin
      m_in_frame = 1'b0;
      m_dir      = 1'b0;
      m_bits.delete();
      m_dout     = '0;
      m_valid    = 1'b0;
      m_over     = 1'b0;
      exp_q.delete();
      return;
    end
    done     = m_in_frame && v && (m_bits.size() == N - 1);
    consumed = m_valid && rd;
    if (consumed) chk("consumed_word", pre_dout, exp_q.pop_front());
    if (done) begin
      m_bits.push_back(b);
      w = assemble(m_dir);
      m_bits.delete();
      if (!m_valid || rd) begin
        m_dout  = w;
        m_valid = 1'b1;
        exp_q.push_back(w);
      end else begin
        m_over = 1'b1;
      end
      m_in_frame = s;
      if (s) m_dir = d;
    end else begin
      if (consumed) m_valid = 1'b0;
      if (s) begin
        m_in_frame = 1'b1;
        m_dir      = d;
        m_bits.delete();
        if (v) m_bits.push_back(b);
      end else if (m_in_frame && v) begin
        m_bits.push_back(b);
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check outputs 1 time unit later.
  task automatic tick(input logic r, input logic s, input logic v, input logic b,
                      input logic d, input logic rd);
    logic [N-1:0] pre;
    rst        = r;
    start      = s;
    sin_valid  = v;
    sin        = b;
    dir        = d;
    dout_ready = rd;
    pre        = dout;
    @(posedge clk);
    model_edge(r, s, v, b, d, rd, pre);
    #1;
    if (dout_valid) valid_cycles++;
    chk1("dout_valid", dout_valid, m_valid);
    chk1("busy", busy, m_in_frame);
    chk1("overrun", overrun, m_over);
    chk("dout", dout, m_dout);
  endtask

  // Sends a full frame, first bit = pat[N-1], start asserted with the first bit.
  task automatic send_frame(input logic [N-1:0] pat, input logic d, input logic rd);
    for (int i = 0; i < N; i++) tick(1'b0, (i == 0), 1'b1, pat[N-1-i], d, rd);
  endtask

  initial begin
    logic [N-1:0] pat;
    logic         r, s, v, b, d, rd;

    rst = 1'b1; start = 1'b0; sin_valid = 1'b0; sin = 1'b0; dir = 1'b0; dout_ready = 1'b0;
    pat = 8'b10110010;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_dout", dout, '0);
    chk1("reset_valid", dout_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_overrun", overrun, 1'b0);

    // MSB-first frame
    send_frame(pat, 1'b1, 1'b1);
    chk("msb_first_dout", dout, 8'hB2);
    chk1("msb_first_valid", dout_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk1("consume_clears_valid", dout_valid, 1'b0);

    // LSB-first frame
    send_frame(pat, 1'b0, 1'b1);
    chk("lsb_first_dout", dout, 8'h4D);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Gap of three invalid cycles between bits 3 and 4; dir toggles are ignored
    for (int i = 0; i < 3; i++) tick(1'b0, (i == 0), 1'b1, pat[N-1-i], 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk1("gap_busy", busy, 1'b1);
    end
    for (int i = 3; i < N; i++) tick(1'b0, 1'b0, 1'b1, pat[N-1-i], 1'b0, 1'b1);
    chk("gap_dout", dout, 8'hB2);
    chk1("gap_valid", dout_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun with consumer stalled
    send_frame(pat, 1'b1, 1'b0);
    chk1("ovr_first_no_overrun", overrun, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("ovr_held_dout", dout, 8'hB2);
    chk1("ovr_flag", overrun, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk1("ovr_sticky", overrun, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("ovr_cleared_by_rst", overrun, 1'b0);

    // Restart after 5 bits, then 0xFF: exactly one word delivered
    valid_cycles = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, (i == 0), 1'b1, 1'($urandom), 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    chk("restart_dout", dout, 8'hFF);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_int("restart_valid_count", valid_cycles, 1);
    chk1("restart_no_overrun", overrun, 1'b0);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) tick(1'b0, (i == 0), 1'b1, 1'($urandom), 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_dout", dout, '0);
    chk1("midrst_valid", dout_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_overrun", overrun, 1'b0);
    send_frame(pat, 1'b1, 1'b1);
    chk("midrst_new_frame", dout, 8'hB2);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 149) == 0);
      s  = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      d  = 1'($urandom);
      rd = ($urandom_range(0, 2) != 0);
      // A start on the very edge that finishes a frame is left to directed tests.
      if (m_in_frame && v && (m_bits.size() == N - 1)) s = 1'b0;
      tick(r, s, v, b, d, rd);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
